// File: rtl/ann_fc_seq.sv
// ann_fc_seq: three-layer fully-connected fixed-point network evaluated
// sequentially, one input node per cycle, all output lanes in parallel.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   in_valid/ready  input vector handshake (in_ready only in IDLE)
//   input_ANN       layer-1 input vector, node 0 in the LSBs
//   relu_last       apply ReLU to layer 3, captured at acceptance
//   w_rd/w_layer/   weight read request: layer select and input-node index
//   w_addr
//   w_data          weights for the requested node, lane j -> output node j,
//                   valid one cycle after w_rd
//   out_valid/ready result handshake (held in DONE until out_ready)
//   output_ANN      layer-3 result vector, held until next layer-3 writeback
//   sat_flag        sticky: some writeback saturated in this inference
//   busy            FSM is not in IDLE
module ann_fc_seq #(
  parameter int DATA_WIDTH     = 16,
  parameter int FRAC_BITS      = 8,
  parameter int INPUT_NODES_L1 = 100,
  parameter int INPUT_NODES_L2 = 32,
  parameter int INPUT_NODES_L3 = 10,
  parameter int OUTPUT_NODES   = 4,
  parameter int MAX_NODES      = 32,
  parameter int ADDR_WIDTH     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_WIDTH*INPUT_NODES_L1-1:0] input_ANN,
  input  logic                               relu_last,
  output logic                               w_rd,
  output logic [1:0]                         w_layer,
  output logic [ADDR_WIDTH-1:0]              w_addr,
  input  logic [DATA_WIDTH*MAX_NODES-1:0]    w_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH*OUTPUT_NODES-1:0] output_ANN,
  output logic                               sat_flag,
  output logic                               busy
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = 2 * DATA_WIDTH + 8;
  localparam int CW = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] N1    = CW'(INPUT_NODES_L1);
  localparam logic [CW-1:0] N2    = CW'(INPUT_NODES_L2);
  localparam logic [CW-1:0] N3    = CW'(INPUT_NODES_L3);
  localparam logic [CW-1:0] NOUT  = CW'(OUTPUT_NODES);
  localparam logic [CW-1:0] LAST1 = CW'(INPUT_NODES_L1 + 1);
  localparam logic [CW-1:0] LAST2 = CW'(INPUT_NODES_L2 + 1);
  localparam logic [CW-1:0] LAST3 = CW'(INPUT_NODES_L3 + 1);

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, RUN_L1, RUN_L2, RUN_L3, DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]                 r_cnt;
  logic                          r_rd_d;
  logic [ADDR_WIDTH-1:0]         r_idx_d;
  logic [DW*INPUT_NODES_L1-1:0]  r_x_in;
  logic [DW*MAX_NODES-1:0]       r_h;
  logic signed [AW-1:0]          r_acc [MAX_NODES];
  logic                          r_relu;
  logic                          r_sat;
  logic [DW*OUTPUT_NODES-1:0]    r_out;

  logic [CW-1:0]                 w_nin;
  logic [CW-1:0]                 w_nout;
  logic                          w_run;
  logic                          w_wb;
  logic                          w_relu_en;
  logic [MAX_NODES-1:0]          w_lane;
  logic signed [DW-1:0]          w_x;
  logic signed [PW-1:0]          w_prod [MAX_NODES];
  logic signed [AW-1:0]          w_sh   [MAX_NODES];
  logic signed [DW-1:0]          w_res  [MAX_NODES];
  logic [MAX_NODES-1:0]          w_clip;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    w_layer   = 2'd0;
    w_nin     = '0;
    w_nout    = '0;
    w_run     = 1'b0;
    w_relu_en = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_next = RUN_L1;
      end
      RUN_L1: begin
        w_run   = 1'b1;
        w_layer = 2'd0;
        w_nin   = N1;
        w_nout  = N2;
        if (r_cnt == LAST1) w_next = RUN_L2;
      end
      RUN_L2: begin
        w_run   = 1'b1;
        w_layer = 2'd1;
        w_nin   = N2;
        w_nout  = N3;
        if (r_cnt == LAST2) w_next = RUN_L3;
      end
      RUN_L3: begin
        w_run     = 1'b1;
        w_layer   = 2'd2;
        w_nin     = N3;
        w_nout    = NOUT;
        w_relu_en = r_relu;
        if (r_cnt == LAST3) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    w_rd   = w_run && (r_cnt < w_nin);
    w_wb   = w_run && (r_cnt == w_nin + CW'(1));
    w_addr = w_rd ? r_cnt[ADDR_WIDTH-1:0] : '0;
  end

  // Operand for the beat now arriving on w_data: index captured with the
  // read strobe one cycle earlier.
  always_comb begin
    w_x = '0;
    if (r_state == RUN_L1) begin
      for (int unsigned i = 0; i < INPUT_NODES_L1; i++)
        if (r_idx_d == ADDR_WIDTH'(i)) w_x = r_x_in[i*DW +: DW];
    end else begin
      for (int unsigned i = 0; i < MAX_NODES; i++)
        if (r_idx_d == ADDR_WIDTH'(i)) w_x = r_h[i*DW +: DW];
    end
  end

  // Per-lane product, floor shift, saturation, then ReLU. Clipping is
  // detected before ReLU so a clipped negative still sets the flag.
  always_comb begin
    for (int unsigned j = 0; j < MAX_NODES; j++) begin
      w_lane[j] = CW'(j) < w_nout;
      w_prod[j] = PW'(w_x) * PW'($signed(w_data[j*DW +: DW]));
      w_sh[j]   = r_acc[j] >>> FRAC_BITS;
      w_clip[j] = 1'b0;
      if (w_sh[j] > SAT_MAX) begin
        w_res[j]  = SAT_MAX[DW-1:0];
        w_clip[j] = 1'b1;
      end else if (w_sh[j] < SAT_MIN) begin
        w_res[j]  = SAT_MIN[DW-1:0];
        w_clip[j] = 1'b1;
      end else begin
        w_res[j]  = w_sh[j][DW-1:0];
      end
      if (w_relu_en && w_res[j][DW-1]) w_res[j] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_rd_d  <= 1'b0;
      r_idx_d <= '0;
      r_x_in  <= '0;
      r_h     <= '0;
      r_relu  <= 1'b0;
      r_sat   <= 1'b0;
      r_out   <= '0;
      for (int unsigned j = 0; j < MAX_NODES; j++) r_acc[j] <= '0;
    end else begin
      r_rd_d  <= w_rd;
      r_idx_d <= w_addr;
      r_cnt   <= (w_run && !w_wb) ? r_cnt + CW'(1) : '0;

      if (r_state == IDLE && in_valid) begin
        r_x_in <= input_ANN;
        r_relu <= relu_last;
        r_sat  <= 1'b0;
        for (int unsigned j = 0; j < MAX_NODES; j++) r_acc[j] <= '0;
      end

      if (w_wb) begin
        if (r_state == RUN_L3) begin
          for (int unsigned j = 0; j < OUTPUT_NODES; j++)
            r_out[j*DW +: DW] <= w_res[j];
        end else begin
          for (int unsigned j = 0; j < MAX_NODES; j++)
            if (w_lane[j]) r_h[j*DW +: DW] <= w_res[j];
        end
        r_sat <= r_sat | (|(w_clip & w_lane));
        for (int unsigned j = 0; j < MAX_NODES; j++) r_acc[j] <= '0;
      end else if (w_run && r_rd_d) begin
        for (int unsigned j = 0; j < MAX_NODES; j++)
          if (w_lane[j]) r_acc[j] <= r_acc[j] + AW'(w_prod[j]);
      end
    end
  end

  assign output_ANN = r_out;
  assign sat_flag   = r_sat;

endmodule

// File: tb/tb_ann_fc_seq.sv
// Bench for ann_fc_seq with a small network (4-3-2-2, three weight lanes).
// A registered weight memory answers w_rd one cycle later and drives a
// filler pattern otherwise; a reference model pushes expected results into
// a scoreboard that is drained at each output hand-off.
module tb_ann_fc_seq;

  localparam int DW  = 16;
  localparam int FB  = 8;
  localparam int L1  = 4;
  localparam int L2  = 3;
  localparam int L3  = 2;
  localparam int NO  = 2;
  localparam int MX  = 3;
  localparam int AWD = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [DW*L1-1:0]    input_ANN;
  logic                relu_last;
  logic                w_rd;
  logic [1:0]          w_layer;
  logic [AWD-1:0]      w_addr;
  logic [DW*MX-1:0]    w_data;
  logic                out_valid;
  logic                out_ready;
  logic [DW*NO-1:0]    output_ANN;
  logic                sat_flag;
  logic                busy;

  always #5 clk = ~clk;

  ann_fc_seq #(
    .DATA_WIDTH(DW), .FRAC_BITS(FB), .INPUT_NODES_L1(L1),
    .INPUT_NODES_L2(L2), .INPUT_NODES_L3(L3), .OUTPUT_NODES(NO),
    .MAX_NODES(MX), .ADDR_WIDTH(AWD)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .input_ANN(input_ANN), .relu_last(relu_last), .w_rd(w_rd),
    .w_layer(w_layer), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .output_ANN(output_ANN),
    .sat_flag(sat_flag), .busy(busy)
  );

  logic [15:0] wmem [3][8][MX];

  always @(posedge clk) begin
    if (w_rd && w_layer < 2'd3 && w_addr < 8) begin
      for (int j = 0; j < MX; j++) w_data[j*DW +: DW] <= wmem[w_layer][w_addr[2:0]][j];
    end else begin
      w_data <= {MX{16'h5555}};
    end
  end

  logic [9:0] wlog [$];
  always @(negedge clk) if (w_rd) wlog.push_back({w_layer, w_addr});

  logic [DW*NO-1:0] sb_out [$];
  logic             sb_sat [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nin_of(input int l);
    return (l == 0) ? L1 : (l == 1) ? L2 : L3;
  endfunction

  function automatic int nout_of(input int l);
    return (l == 0) ? L2 : (l == 1) ? L3 : NO;
  endfunction

  // Reference: full-precision sums, floor shift, clip, ReLU.
  function automatic void model(input logic [DW*L1-1:0] x, input logic relu,
                                output logic [DW*NO-1:0] y, output logic sat);
    longint v [L1];
    longint nv [L1];
    longint a;
    longint s;
    sat = 1'b0;
    for (int i = 0; i < L1; i++) v[i] = longint'($signed(x[i*DW +: DW]));
    for (int i = 0; i < L1; i++) nv[i] = 0;
    for (int l = 0; l < 3; l++) begin
      for (int j = 0; j < nout_of(l); j++) begin
        a = 0;
        for (int i = 0; i < nin_of(l); i++) a += v[i] * longint'($signed(wmem[l][i][j]));
        s = a >>> FB;
        if (s > 32767) begin s = 32767; sat = 1'b1; end
        else if (s < -32768) begin s = -32768; sat = 1'b1; end
        if ((l < 2 || relu) && s < 0) s = 0;
        nv[j] = s;
      end
      for (int j = 0; j < nout_of(l); j++) v[j] = nv[j];
    end
    y = '0;
    for (int j = 0; j < NO; j++) y[j*DW +: DW] = 16'(nv[j]);
  endfunction

  task automatic set_w(input int l, input logic [15:0] val);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < MX; j++)
        wmem[l][i][j] = (j < nout_of(l)) ? val : 16'h7FFF;
  endtask

  task automatic run_inf(input logic [DW*L1-1:0] x, input logic relu, input int hold,
                         input bit poke, output logic [DW*NO-1:0] got, output logic got_sat);
    logic [DW*NO-1:0] e;
    logic             es;
    logic [DW*NO-1:0] snap;
    logic [9:0]       ent;
    int               lat;
    int               k;
    model(x, relu, e, es);
    sb_out.push_back(e);
    sb_sat.push_back(es);
    wlog.delete();
    check("idle_in_ready", in_ready, 1);
    input_ANN = x;
    relu_last = relu;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    input_ANN = '1;
    relu_last = ~relu;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 15);
    check("done_in_ready", in_ready, 0);
    check("done_busy", busy, 1);
    snap = output_ANN;
    for (int c = 0; c < hold; c++) begin
      in_valid  = poke & c[0];
      input_ANN = {$urandom, $urandom};
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_out", output_ANN, snap);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    got     = output_ANN;
    got_sat = sat_flag;
    check("sb_out", output_ANN, sb_out.pop_front());
    check("sb_sat", sat_flag, sb_sat.pop_front());
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_in_ready", in_ready, 1);
    check("post_out_valid", out_valid, 0);
    check("post_busy", busy, 0);
    check("post_hold", output_ANN, got);
    check("wseq_len", wlog.size(), L1 + L2 + L3);
    k = 0;
    for (int l = 0; l < 3; l++)
      for (int a = 0; a < nin_of(l); a++) begin
        ent = (k < wlog.size()) ? wlog[k] : 10'h3FF;
        check("wseq", ent, {2'(l), 8'(a)});
        k++;
      end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [DW*L1-1:0] x_one;
  logic [DW*L1-1:0] x_big;
  logic [DW*L1-1:0] x_rnd;
  logic [DW*NO-1:0] got;
  logic             gs;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    relu_last = 1'b0;
    input_ANN = '0;
    for (int l = 0; l < 3; l++) set_w(l, 16'h0100);
    x_one = {L1{16'h0100}};
    x_big = {L1{16'h6400}};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_output", output_ANN, 0);
    check("rst_w_rd", w_rd, 0);
    check("rst_sat", sat_flag, 0);

    run_inf(x_one, 1'b1, 0, 1'b0, got, gs);
    check("ones_out", got, 32'h18001800);
    check("ones_sat", gs, 0);

    set_w(2, 16'hFF00);
    run_inf(x_one, 1'b0, 0, 1'b0, got, gs);
    check("neg_norelu_out", got, 32'hE800E800);
    run_inf(x_one, 1'b1, 0, 1'b0, got, gs);
    check("neg_relu_out", got, 32'h00000000);
    set_w(2, 16'h0100);

    run_inf(x_big, 1'b1, 0, 1'b0, got, gs);
    check("big_out", got, 32'h7FFF7FFF);
    check("big_sat", gs, 1);

    run_inf(x_one, 1'b1, 10, 1'b1, got, gs);
    check("bp_out", got, 32'h18001800);
    check("bp_sat", gs, 0);

    // Reset in the second RUN_L2 cycle.
    input_ANN = x_one;
    relu_last = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("midrst_layer", w_layer, 1);
    check("midrst_addr", w_addr, 1);
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_w_rd", w_rd, 0);
    check("midrst_w_layer", w_layer, 0);
    check("midrst_w_addr", w_addr, 0);
    check("midrst_output", output_ANN, 0);
    check("midrst_sat", sat_flag, 0);
    run_inf(x_one, 1'b1, 0, 1'b0, got, gs);
    check("after_rst_out", got, 32'h18001800);

    for (int t = 0; t < 4; t++) begin
      for (int l = 0; l < 3; l++)
        for (int i = 0; i < 8; i++)
          for (int j = 0; j < MX; j++)
            wmem[l][i][j] = 16'($urandom_range(0, 1023)) - 16'd512;
      for (int i = 0; i < L1; i++)
        x_rnd[i*DW +: DW] = 16'($urandom_range(0, 2047)) - 16'd1024;
      run_inf(x_rnd, 1'($urandom_range(0, 1)), t, 1'b1, got, gs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ann_fc_seq.md
ANN_FC_SEQ -- requirements
Module: ann_fc_seq

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- DATA_WIDTH, 16, signed fixed-point word width.
- FRAC_BITS, 8, fractional bits of every word.
- INPUT_NODES_L1, 100, layer-1 input count.
- INPUT_NODES_L2, 32, layer-1 outputs and layer-2 inputs.
- INPUT_NODES_L3, 10, layer-2 outputs and layer-3 inputs.
- OUTPUT_NODES, 4, layer-3 output count.
- MAX_NODES, 32, lane count of the weight bus; at least the largest of L2, L3 and OUTPUT_NODES.
- ADDR_WIDTH, 8, weight address width.

REQ-002 SHALL have these ports (name, direction, width, meaning). One clock; reset is synchronous and active-high.
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- in_valid, in, 1, input vector offered.
- in_ready, out, 1, block can accept a vector.
- input_ANN, in, DATA_WIDTH*INPUT_NODES_L1, input vector; node 0 in the LSBs.
- relu_last, in, 1, 1 applies ReLU to layer 3; sampled at acceptance.
- w_rd, out, 1, weight read strobe.
- w_layer, out, 2, layer select: 0, 1 or 2.
- w_addr, out, ADDR_WIDTH, input-node index.
- w_data, in, DATA_WIDTH*MAX_NODES, weights for input w_addr; lane j feeds output node j.
- out_valid, out, 1, result available.
- out_ready, in, 1, consumer accepts the result.
- output_ANN, out, DATA_WIDTH*OUTPUT_NODES, result vector.
- sat_flag, out, 1, sticky saturation flag for the current inference.
- busy, out, 1, high when the FSM is not in IDLE.

Function
REQ-003 FSM states SHALL be IDLE, RUN_L1, RUN_L2, RUN_L3, DONE.
REQ-004 in_ready SHALL be 1 only in IDLE. in_valid is ignored in all other states.
REQ-005 On an edge with in_valid and in_ready high, the block SHALL:
- register input_ANN and relu_last;
- clear sat_flag and all accumulators;
- enter RUN_L1.
REQ-006 Each RUN_Lk SHALL last Nin_k+2 cycles, where Nin_k is that layer's input count:
- Nin_k address cycles, with w_rd=1 and w_addr = 0..Nin_k-1 ascending;
- one drain cycle;
- one writeback cycle.
REQ-007 w_data SHALL be treated as valid exactly one cycle after the matching w_rd. Lanes at or above the layer's output count SHALL be ignored.
REQ-008 Per valid weight beat, acc[j] SHALL increase by x[i]*w[i][j]:
- the product is full precision (2*DATA_WIDTH bits);
- acc is 2*DATA_WIDTH+8 bits, signed;
- acc does not wrap for the parameter ranges above.
REQ-009 Writeback SHALL compute acc >>> FRAC_BITS (arithmetic shift, floor) and saturate to [-2^(DW-1), 2^(DW-1)-1].
- Any clipped value sets sat_flag.
- ReLU then forces negative results to 0 for layers 1 and 2, and for layer 3 only when relu_last=1.
- The results become the next layer's inputs; accumulators clear.
REQ-010 out_valid SHALL rise exactly INPUT_NODES_L1+INPUT_NODES_L2+INPUT_NODES_L3+6 edges after the acceptance edge.
REQ-011 In DONE, out_valid=1, and output_ANN and sat_flag SHALL hold stable until an edge with out_ready=1. The FSM then returns to IDLE and out_valid drops.
REQ-012 output_ANN SHALL keep its last value after the hand-off, until the next writeback of layer 3.
REQ-013 w_rd SHALL be 0 outside address cycles. w_addr and w_layer are don't-care while w_rd=0.
REQ-014 busy SHALL be 1 in every state except IDLE.

Reset
REQ-015 On reset (synchronous, active-high), at any state including mid-layer, the block SHALL:
- enter IDLE;
- set in_ready=1 and busy=0;
- set out_valid=0, w_rd=0, w_layer=0, w_addr=0;
- set output_ANN=0 and sat_flag=0;
- clear all accumulators and layer registers.
REQ-016 Reset SHALL take priority over in_valid and out_ready in the same cycle.

Verification (parameters: DW=16, FRAC=8, L1=4, L2=3, L3=2, OUT=2, MAX=3)
REQ-017 Reset release: in_ready=1, busy=0, out_valid=0, output_ANN=0, w_rd=0.
REQ-018 All inputs and weights 0x0100, relu_last=1:
- out_valid exactly 15 edges after acceptance;
- output_ANN={0x1800,0x1800}, sat_flag=0;
- w_addr sequence 0-3, 0-2, 0-1, with w_layer 0, 1, 2 respectively.
REQ-019 As REQ-018, but layer-3 weights are 0xFF00 (-1.0):
- relu_last=0 gives output 0xE800 per node;
- relu_last=1 gives 0x0000.
REQ-020 Inputs 0x6400, all weights 0x0100: layer-1 values clip to 0x7FFF, sat_flag=1, and the final output is 0x7FFF.
REQ-021 Backpressure and handshake rules:
- hold out_ready=0 for 10 cycles in DONE: output_ANN and out_valid stay stable, in_ready=0;
- in_valid pulses during this time are ignored;
- out_ready=1 gives in_ready=1 on the next cycle.
REQ-022 Assert reset in the second RUN_L2 cycle: the next cycle shows IDLE values per REQ-015; a new inference then yields the REQ-018 result.
